led_pio_write_arbiter: RTL and testbench

- Avalon-MM master that owns the write port of the 4-bit LED PIO slave and shares it between two client requesters plus an internal blink generator.
- Each grant produces exactly one single-cycle write to PIO address 0 (zero-wait-state slave).
- Keeps a shadow copy of the LED value so the blink path can toggle bits without a read-back.
- Sits between the traffic-status logic / HPS bridge clients and the LED PIO.

---
 rtl/led_pio_write_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_led_pio_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_write_arbiter.sv
// Avalon-MM write master for the 4-bit LED PIO: arbitrates two client requesters
// and a periodic blink generator, issuing one single-cycle write per grant.
`timescale 1ns/1ps

module led_pio_write_arbiter #(
    parameter int LED_W     = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int CNT_W     = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_0,
    input  logic [LED_W-1:0] data_0,
    output logic             ack_0,
    input  logic             req_1,
    input  logic [LED_W-1:0] data_1,
    output logic             ack_1,
    input  logic             blink_en,
    input  logic [LED_W-1:0] blink_mask,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    output logic [LED_W-1:0] led_shadow,
    output logic             busy
);

    // Handshake: req_x is a level held by the client until ack_x; ack_x is a
    // one-cycle pulse in DONE. A request dropped before its grant is forgotten,
    // a request dropped after its grant still completes and still acks.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SRC_C0    = 2'd0;
    localparam logic [1:0] SRC_C1    = 2'd1;
    localparam logic [1:0] SRC_BLINK = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam int               PAD_W    = 32 - LED_W;

    logic [1:0]       state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [LED_W-1:0] wdata_q, wdata_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_pend_q, blink_pend_d;
    logic             cs_q, cs_d;
    logic             write_n_q, write_n_d;
    logic [31:0]      writedata_q, writedata_d;
    logic             ack_0_q, ack_0_d;
    logic             ack_1_q, ack_1_d;
    logic [LED_W-1:0] shadow_q, shadow_d;
    logic             busy_q, busy_d;

    logic             blink_tick;
    logic             grant_valid;
    logic [1:0]       grant_src;
    logic [LED_W-1:0] grant_data;
    logic             blink_done;

    // Blink tick generator: free-running only while enabled.
    always_comb begin
        blink_tick = blink_en && (cnt_q == CNT_LAST);
        cnt_d      = cnt_q;
        if (!blink_en) begin
            cnt_d = '0;
        end else if (blink_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Source selection: round-robin between clients, blink only when both idle.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_C0;
        grant_data  = data_0;
        if (req_0 && req_1) begin
            grant_valid = 1'b1;
            if (last_grant_q) begin
                grant_src  = SRC_C0;
                grant_data = data_0;
            end else begin
                grant_src  = SRC_C1;
                grant_data = data_1;
            end
        end else if (req_0) begin
            grant_valid = 1'b1;
            grant_src   = SRC_C0;
            grant_data  = data_0;
        end else if (req_1) begin
            grant_valid = 1'b1;
            grant_src   = SRC_C1;
            grant_data  = data_1;
        end else if (blink_pend_q) begin
            grant_valid = 1'b1;
            grant_src   = SRC_BLINK;
            grant_data  = shadow_q ^ blink_mask;
        end
    end

    // Main FSM; every output is computed one cycle ahead so it comes out of a flop.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        cs_d         = 1'b0;
        write_n_d    = 1'b1;
        writedata_d  = writedata_q;
        ack_0_d      = 1'b0;
        ack_1_d      = 1'b0;
        shadow_d     = shadow_q;
        blink_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d     = ST_WRITE;
                    src_d       = grant_src;
                    wdata_d     = grant_data;
                    cs_d        = 1'b1;
                    write_n_d   = 1'b0;
                    writedata_d = {{PAD_W{1'b0}}, grant_data};
                    if (grant_src != SRC_BLINK) begin
                        last_grant_d = (grant_src == SRC_C1);
                    end
                end
            end
            ST_WRITE: begin
                state_d  = ST_DONE;
                shadow_d = wdata_q;
                ack_0_d  = (src_q == SRC_C0);
                ack_1_d  = (src_q == SRC_C1);
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                blink_done = (src_q == SRC_BLINK);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // A tick landing while a blink write is retiring is treated as a fresh request.
    always_comb begin
        blink_pend_d = blink_pend_q;
        if (blink_done) begin
            blink_pend_d = 1'b0;
        end
        if (blink_tick) begin
            blink_pend_d = 1'b1;
        end
        if (!blink_en) begin
            blink_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_C0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            blink_pend_q <= 1'b0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= '0;
            ack_0_q      <= 1'b0;
            ack_1_q      <= 1'b0;
            shadow_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            blink_pend_q <= blink_pend_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            writedata_q  <= writedata_d;
            ack_0_q      <= ack_0_d;
            ack_1_q      <= ack_1_d;
            shadow_q     <= shadow_d;
            busy_q       <= busy_d;
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = writedata_q;
    assign ack_0          = ack_0_q;
    assign ack_1          = ack_1_q;
    assign led_shadow     = shadow_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Directed bench for led_pio_write_arbiter: expected writes and acks are queued
// by the stimulus and consumed by a monitor that watches the Avalon port.
`timescale 1ns/1ps

module tb_led_pio_write_arbiter;

    localparam int LED_W     = 4;
    localparam int BLINK_DIV = 4;
    localparam int CNT_W     = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_0, req_1, blink_en;
    logic [LED_W-1:0] data_0, data_1, blink_mask;
    logic             ack_0, ack_1;
    logic [1:0]       avm_address;
    logic             avm_chipselect, avm_write_n;
    logic [31:0]      avm_writedata;
    logic [LED_W-1:0] led_shadow;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_wr_q[$];
    logic [0:0]  exp_ack_q[$];

    led_pio_write_arbiter #(
        .LED_W     (LED_W),
        .BLINK_DIV (BLINK_DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_0          (req_0),
        .data_0         (data_0),
        .ack_0          (ack_0),
        .req_1          (req_1),
        .data_1         (data_1),
        .ack_1          (ack_1),
        .blink_en       (blink_en),
        .blink_mask     (blink_mask),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .led_shadow     (led_shadow),
        .busy           (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect || !avm_write_n)
                check("strobe_pair", 32'(avm_chipselect), 32'(!avm_write_n));
            if (avm_chipselect) begin
                check("wr_addr", 32'(avm_address), 32'd0);
                if (exp_wr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got 'h%0h, required no write", avm_writedata);
                end else begin
                    check("wr_data", avm_writedata, exp_wr_q.pop_front());
                end
            end
            if (ack_0 || ack_1) begin
                check("ack_exclusive", 32'(ack_0 & ack_1), 32'd0);
                if (exp_ack_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: got ack_0=%0b ack_1=%0b, required no ack", ack_0, ack_1);
                end else begin
                    check("ack_src", 32'(ack_1), 32'(exp_ack_q.pop_front()));
                end
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        req_0      = 1'b0;
        req_1      = 1'b0;
        blink_en   = 1'b0;
        data_0     = '0;
        data_1     = '0;
        blink_mask = '0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_ack(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ack_0 || ack_1) seen = 1'b1;
        end
        check("ack_wait", 32'(seen), 32'd1);
    endtask

    task automatic push_wr(input logic [31:0] d);
        exp_wr_q.push_back(d);
    endtask

    task automatic push_ack(input logic [0:0] a);
        exp_ack_q.push_back(a);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; blink_en = 1'b0;
        data_0 = '0; data_1 = '0; blink_mask = '0;

        // Reset state and single client-0 write
        do_reset();
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_write_n", 32'(avm_write_n), 32'd1);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        check("rst_ack", 32'({ack_0, ack_1}), 32'd0);
        check("rst_shadow", 32'(led_shadow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_0 = 1'b1; data_0 = 4'hA;
        push_wr(32'h0000_000A); push_ack(1'b0);
        step(1);
        check("t1_cs", 32'(avm_chipselect), 32'd1);
        check("t1_write_n", 32'(avm_write_n), 32'd0);
        check("t1_wdata", avm_writedata, 32'h0000_000A);
        check("t1_busy", 32'(busy), 32'd1);
        step(1);
        check("t1_ack0", 32'(ack_0), 32'd1);
        check("t1_shadow", 32'(led_shadow), 32'hA);
        req_0 = 1'b0;
        step(1);
        check("t1_ack0_pulse", 32'(ack_0), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Round-robin with both clients held
        do_reset();
        data_0 = 4'd3; data_1 = 4'd5; req_0 = 1'b1; req_1 = 1'b1;
        push_wr(32'd3); push_wr(32'd5); push_wr(32'd3); push_wr(32'd5);
        push_ack(1'b0); push_ack(1'b1); push_ack(1'b0); push_ack(1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(c);
            check("rr_spacing", 32'(c), (k == 0) ? 32'd2 : 32'd3);
        end
        req_0 = 1'b0; req_1 = 1'b0;
        step(3);
        check("rr_shadow", 32'(led_shadow), 32'd5);

        // Blink alternation and client winning over a simultaneous tick
        do_reset();
        req_0 = 1'b1; data_0 = 4'hA;
        push_wr(32'hA); push_ack(1'b0);
        wait_ack(c);
        req_0 = 1'b0;
        step(2);
        check("bl_shadow_init", 32'(led_shadow), 32'hA);
        blink_mask = 4'hF; blink_en = 1'b1;
        push_wr(32'h5); push_wr(32'hA);
        step(11);
        req_1 = 1'b1; data_1 = 4'h6;
        push_wr(32'h6); push_ack(1'b1);
        push_wr(32'h9); push_wr(32'h6);
        wait_ack(c);
        check("bl_req1_latency", 32'(c), 32'd2);
        req_1 = 1'b0;
        step(9);
        blink_en = 1'b0;
        step(3);
        check("bl_shadow_end", 32'(led_shadow), 32'h6);
        check("bl_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        // Data captured at grant; short req_0 pulse while busy is ignored
        do_reset();
        req_1 = 1'b1; data_1 = 4'h6;
        push_wr(32'h6); push_ack(1'b1);
        step(1);
        data_1 = 4'h9; req_0 = 1'b1; data_0 = 4'hD;
        step(1);
        req_0 = 1'b0;
        check("cap_ack1", 32'(ack_1), 32'd1);
        req_1 = 1'b0;
        step(4);
        check("cap_shadow", 32'(led_shadow), 32'h6);

        // Blink held off by a continuous client, then exactly one coalesced write
        do_reset();
        req_0 = 1'b1; data_0 = 4'h3; blink_mask = 4'hF; blink_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_wr(32'h3); push_ack(1'b0);
        end
        push_wr(32'hC);
        for (int k = 0; k < 5; k++) wait_ack(c);
        req_0 = 1'b0;
        step(3);
        blink_en = 1'b0;
        check("coal_shadow", 32'(led_shadow), 32'hC);
        step(4);
        check("coal_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        // Reset during WRITE aborts the transaction
        do_reset();
        req_0 = 1'b1; data_0 = 4'h5;
        push_wr(32'h5); push_ack(1'b0);
        wait_ack(c);
        req_0 = 1'b0;
        step(2);
        req_0 = 1'b1; data_0 = 4'h7;
        step(1);
        check("mid_cs", 32'(avm_chipselect), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        check("mid_rst_write_n", 32'(avm_write_n), 32'd1);
        check("mid_rst_shadow", 32'(led_shadow), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step(2);
        reset = 1'b0; req_1 = 1'b1; data_1 = 4'h2;
        push_wr(32'h7); push_wr(32'h2);
        push_ack(1'b0); push_ack(1'b1);
        wait_ack(c);
        wait_ack(c);
        req_0 = 1'b0; req_1 = 1'b0;
        step(3);
        check("mid_shadow", 32'(led_shadow), 32'h2);

        // final report
        check("final_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("final_ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
